diff_sq_pipe: RTL and testbench

Parametrised, pipelined successor to the 3-bit square-difference datapath. It takes W-bit unsigned operand pairs under a valid/ready handshake and computes a per-transaction selectable function: (a²−b²)², |a²−b²| or a²+b². Three register stages, full backpressure and a sign flag make it suitable as a streaming mode engine inside the multiclock manager's per-domain compute path.

---
 rtl/diff_sq_pipe.sv | 131 +++++++++++++
 tb/tb_diff_sq_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/diff_sq_pipe.sv
// Three-stage streaming engine computing (a^2-b^2)^2, |a^2-b^2| or a^2+b^2 per transaction.
// Define DIFF_SQ_ACC_EN to add a running accumulator of emitted results (acc_clr / acc_out).
module diff_sq_pipe #(
  parameter int W     = 3,
  parameter int OUT_W = 4*W
`ifdef DIFF_SQ_ACC_EN
  ,
  parameter int ACC_W = 4*W+4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
`ifdef DIFF_SQ_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc_out
`endif
);

  localparam int SQ_W  = 2*W;
  localparam int SUM_W = 2*W+1;

  typedef enum logic [1:0] {
    MODE_DSQ = 2'b00,
    MODE_ABS = 2'b01,
    MODE_SUM = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Stage registers
  logic             r1_valid, r2_valid, r3_valid;
  logic [SQ_W-1:0]  r1_a2, r1_b2;
  mode_e            r1_mode, r2_mode;
  logic             r1_neg, r2_neg, r3_neg;
  logic [SQ_W-1:0]  r2_d;
  logic [SUM_W-1:0] r2_s;
  logic [OUT_W-1:0] r3_data;

  // Combinational datapath and ready chain
  logic             w_ld1, w_ld2, w_ld3;
  logic [SQ_W-1:0]  w_a_ext, w_b_ext, w_a2, w_b2;
  logic [OUT_W-1:0] w_d_ext, w_res;

  // Each stage loads when empty or when its current content moves on this cycle.
  assign w_ld3    = !r3_valid || out_ready;
  assign w_ld2    = !r2_valid || w_ld3;
  assign w_ld1    = !r1_valid || w_ld2;
  assign in_ready = w_ld1;

  assign w_a_ext = SQ_W'(a_in);
  assign w_b_ext = SQ_W'(b_in);
  assign w_a2    = w_a_ext * w_a_ext;
  assign w_b2    = w_b_ext * w_b_ext;
  assign w_d_ext = OUT_W'(r2_d);

  always_comb begin
    w_res = '0;
    case (r2_mode)
      MODE_DSQ: w_res = w_d_ext * w_d_ext;
      MODE_ABS: w_res = w_d_ext;
      MODE_SUM: w_res = OUT_W'(r2_s);
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
      r3_data  <= '0;
      r3_neg   <= 1'b0;
    end else begin
      if (w_ld1) r1_valid <= in_valid;
      if (w_ld2) r2_valid <= r1_valid;
      if (w_ld3) begin
        r3_valid <= r2_valid;
        if (r2_valid) begin
          r3_data <= w_res;
          r3_neg  <= r2_neg;
        end
      end
    end
  end

  // NOTE: S1/S2 payload has no reset; the valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (w_ld1 && in_valid) begin
      r1_a2   <= w_a2;
      r1_b2   <= w_b2;
      r1_mode <= mode_e'(mode);
      r1_neg  <= (a_in < b_in);
    end
    if (w_ld2 && r1_valid) begin
      r2_d    <= r1_neg ? (r1_b2 - r1_a2) : (r1_a2 - r1_b2);
      r2_s    <= SUM_W'(r1_a2) + SUM_W'(r1_b2);
      r2_mode <= r1_mode;
      r2_neg  <= r1_neg;
    end
  end

  assign out_valid = r3_valid;
  assign out_data  = r3_data;
  assign out_neg   = r3_neg;

`ifdef DIFF_SQ_ACC_EN
  logic w_out_fire;
  assign w_out_fire = r3_valid && out_ready;

  // Clear takes priority over the running sum, but a coincident result is still added.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
    end else if (acc_clr) begin
      acc_out <= w_out_fire ? ACC_W'(r3_data) : '0;
    end else if (w_out_fire) begin
      acc_out <= acc_out + ACC_W'(r3_data);
    end
  end
`endif

endmodule

// File: tb/tb_diff_sq_pipe.sv
// Directed self-checking bench for diff_sq_pipe at W=3: latency, modes, backpressure,
// reset flush and, with DIFF_SQ_ACC_EN, the accumulator.
module tb_diff_sq_pipe;

  localparam int W     = 3;
  localparam int OUT_W = 4*W;
  localparam int ACC_W = 4*W+4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;
`ifdef DIFF_SQ_ACC_EN
  logic             acc_clr;
  logic [ACC_W-1:0] acc_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  diff_sq_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg)
`ifdef DIFF_SQ_ACC_EN
    ,
    .acc_clr   (acc_clr),
    .acc_out   (acc_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one pair with out_ready=1, verify 3-cycle latency and the result, then consume it.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                         input int exp_data, input logic exp_neg, input string tag,
                         input bit clr_on_emit);
    int cyc;
    a_in = a; b_in = b; mode = m; in_valid = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd3);
    check({tag, " data"}, 32'(out_data), 32'(exp_data));
    check({tag, " neg"}, 32'(out_neg), 32'(exp_neg));
`ifdef DIFF_SQ_ACC_EN
    acc_clr = clr_on_emit;
`else
    if (clr_on_emit) $display("note: accumulator clear requested without accumulator");
`endif
    step();
`ifdef DIFF_SQ_ACC_EN
    acc_clr = 1'b0;
`endif
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   m;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   accepted;
    logic rdy;

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; mode = 2'b00; out_ready = 1'b1;
`ifdef DIFF_SQ_ACC_EN
    acc_clr = 1'b0;
`endif
    step();
    step();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_neg", 32'(out_neg), 32'd0);
`ifdef DIFF_SQ_ACC_EN
    check("reset acc_out", 32'(acc_out), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);

    // Single transactions, mode 00 and a few other corners
    run_one(3'd5, 3'd3, 2'b00, 256,  1'b0, "sq 5,3", 1'b0);
    run_one(3'd3, 3'd5, 2'b00, 256,  1'b1, "sq 3,5", 1'b0);
    run_one(3'd7, 3'd0, 2'b00, 2401, 1'b0, "sq 7,0", 1'b0);
    run_one(3'd6, 3'd6, 2'b00, 0,    1'b0, "sq 6,6", 1'b0);
    run_one(3'd6, 3'd6, 2'b01, 0,    1'b0, "abs 6,6", 1'b0);
    run_one(3'd2, 3'd7, 2'b01, 45,   1'b1, "abs 2,7", 1'b0);
    run_one(3'd7, 3'd7, 2'b10, 98,   1'b0, "sum 7,7", 1'b0);
    run_one(3'd1, 3'd6, 2'b11, 0,    1'b1, "rsv 1,6", 1'b0);

    // Back-to-back stream: modes 01, 10, 11 on (5,3)
    a_in = 3'd5; b_in = 3'd3; in_valid = 1'b1;
    mode = 2'b01; step();
    mode = 2'b10; step();
    mode = 2'b11; step();
    in_valid = 1'b0;
    check("b2b r0 valid", 32'(out_valid), 32'd1);
    check("b2b r0 data", 32'(out_data), 32'd16);
    check("b2b r0 neg", 32'(out_neg), 32'd0);
    step();
    check("b2b r1 valid", 32'(out_valid), 32'd1);
    check("b2b r1 data", 32'(out_data), 32'd34);
    check("b2b r1 neg", 32'(out_neg), 32'd0);
    step();
    check("b2b r2 valid", 32'(out_valid), 32'd1);
    check("b2b r2 data", 32'(out_data), 32'd0);
    check("b2b r2 neg", 32'(out_neg), 32'd0);
    step();
    check("b2b drained", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for 5 cycles with in_valid held high
    vecs[0] = '{a: 3'd5, b: 3'd3, m: 2'b00};  // 256
    vecs[1] = '{a: 3'd7, b: 3'd0, m: 2'b01};  // 49
    vecs[2] = '{a: 3'd1, b: 3'd4, m: 2'b10};  // 17, neg
    vecs[3] = '{a: 3'd6, b: 3'd2, m: 2'b01};  // 32
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in = vecs[accepted].a; b_in = vecs[accepted].b; mode = vecs[accepted].m;
      #1;
      rdy = in_ready;
      step();
      if (rdy) accepted++;
      if (i >= 2) begin
        check("stall valid", 32'(out_valid), 32'd1);
        check("stall data", 32'(out_data), 32'd256);
      end
    end
    check("stall accepts", 32'(accepted), 32'd3);
    a_in = vecs[3].a; b_in = vecs[3].b; mode = vecs[3].m;
    #1;
    check("stall in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("release r1 data", 32'(out_data), 32'd49);
    check("release r1 neg", 32'(out_neg), 32'd0);
    step();
    check("release r2 data", 32'(out_data), 32'd17);
    check("release r2 neg", 32'(out_neg), 32'd1);
    step();
    check("release r3 valid", 32'(out_valid), 32'd1);
    check("release r3 data", 32'(out_data), 32'd32);
    step();
    check("release drained", 32'(out_valid), 32'd0);

    // Reset with two transactions in flight
    a_in = 3'd7; b_in = 3'd0; mode = 2'b00; in_valid = 1'b1;
    step();
    a_in = 3'd5; b_in = 3'd3; mode = 2'b01;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush out_data", 32'(out_data), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush no ghost", 32'(out_valid), 32'd0);
    end
    run_one(3'd4, 3'd1, 2'b10, 17, 1'b0, "post-reset", 1'b0);

`ifdef DIFF_SQ_ACC_EN
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("acc cleared", 32'(acc_out), 32'd0);
    run_one(3'd5, 3'd3, 2'b00, 256, 1'b0, "acc sq a", 1'b0);
    run_one(3'd3, 3'd5, 2'b00, 256, 1'b1, "acc sq b", 1'b0);
    check("acc two 256", 32'(acc_out), 32'd512);
    run_one(3'd5, 3'd3, 2'b01, 16, 1'b0, "acc clr+16", 1'b1);
    check("acc clr with 16", 32'(acc_out), 32'd16);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    for (int i = 0; i < 7; i++) run_one(3'd7, 3'd0, 2'b00, 2401, 1'b0, "acc 2401", 1'b0);
    check("acc 7x2401", 32'(acc_out), 32'd16807);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
